// File: rtl/inference_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// inference_ctrl
//
// Sequences one inference over NUM_ROWS weight rows: for each class index it
// addresses the weight ROM, captures the registered ROM output, offers the row
// to the neuron unit over a valid/ready handshake, then waits for that row's
// popcount score. A running argmax (strictly greater wins, so ties keep the
// lower index) is published on class_o/best_score_o when the inference ends.
//
// Ports
//   clk_i          rising-edge clock
//   reset_ni       asynchronous active-low reset
//   start_i        request an inference (looked at in IDLE only)
//   abort_i        cancel the inference in progress
//   rom_addr_o     weight ROM row address (current class index)
//   rom_weight_i   ROM row data, one cycle after the address
//   row_valid_o    row_data_o/row_idx_o offered to the neuron unit
//   row_ready_i    neuron unit accepts the row
//   row_data_o     captured weight row
//   row_idx_o      class index of the offered row
//   score_valid_i  score for the last accepted row is present
//   score_i        unsigned popcount score
//   busy_o         high whenever not IDLE
//   done_o         one-cycle completion pulse
//   class_o        argmax class of the last completed inference
//   best_score_o   score belonging to class_o
// -----------------------------------------------------------------------------
module inference_ctrl #(
    parameter int NUM_ROWS = 10,
    parameter int ROW_W    = 784,
    parameter int ADDR_W   = 10,
    parameter int SCORE_W  = 10
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [ROW_W-1:0]   rom_weight_i,
    output logic               row_valid_o,
    input  logic               row_ready_i,
    output logic [ROW_W-1:0]   row_data_o,
    output logic [3:0]         row_idx_o,
    input  logic               score_valid_i,
    input  logic [SCORE_W-1:0] score_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         class_o,
    output logic [SCORE_W-1:0] best_score_o
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_ISSUE,
        S_SCORE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [3:0]         best_class_q, best_class_d;
    logic [ROW_W-1:0]   row_data_q, row_data_d;
    logic [3:0]         class_q, class_d;
    logic [SCORE_W-1:0] out_score_q, out_score_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
            row_data_q   <= '0;
            class_q      <= '0;
            out_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_score_q <= best_score_d;
            best_class_q <= best_class_d;
            row_data_q   <= row_data_d;
            class_q      <= class_d;
            out_score_q  <= out_score_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_score_d = best_score_q;
        best_class_d = best_class_q;
        row_data_d   = row_data_q;
        class_d      = class_q;
        out_score_d  = out_score_q;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_ADDR;
                    idx_d        = '0;
                    best_score_d = '0;
                    best_class_d = '0;
                end
            end
            // Address is already on rom_addr_o; this cycle only absorbs the
            // ROM's registered read latency.
            S_ADDR: state_d = S_LATCH;
            S_LATCH: begin
                row_data_d = rom_weight_i;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (row_ready_i) begin
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                if (score_valid_i) begin
                    // Strict compare: an equal later score never displaces
                    // the earlier (lower) class index.
                    if (score_i > best_score_q) begin
                        best_score_d = score_i;
                        best_class_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = 4'(idx_q + 4'd1);
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                class_d     = best_class_q;
                out_score_d = best_score_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything outside IDLE, including the DONE
        // cycle: the published result is left untouched and no pulse is seen.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            idx_d        = idx_q;
            best_score_d = best_score_q;
            best_class_d = best_class_q;
            row_data_d   = row_data_q;
            class_d      = class_q;
            out_score_d  = out_score_q;
            done_o       = 1'b0;
        end
    end

    assign rom_addr_o   = ADDR_W'(idx_q);
    assign row_idx_o    = idx_q;
    assign row_data_o   = row_data_q;
    assign row_valid_o  = (state_q == S_ISSUE);
    assign busy_o       = (state_q != S_IDLE);
    assign class_o      = class_q;
    assign best_score_o = out_score_q;

endmodule
